// File: rtl/i2c_target.sv
// I2C target: synchronized/edge-detected SCL+SDA, address match, byte receive and transmit with ACK handling.
// Optional glitch filter on the synchronized pins is enabled by defining I2C_GLITCH_FILTER_EN.
module i2c_target #(
    parameter int SIZE_DATA = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_SCL,
    input  logic                 i_SDA,
    output logic                 o_SDA_oe,
    input  logic [6:0]           i_own_addr,
    input  logic [SIZE_DATA-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_load,
    output logic [SIZE_DATA-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_start,
    output logic                 o_stop,
    output logic                 o_busy
);

    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE} state_t;

    logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
    logic scl_dly_q, sda_dly_q;
    logic scl_f, sda_f;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
        end else begin
            scl_s1_q <= i_SCL;
            scl_s2_q <= scl_s1_q;
            sda_s1_q <= i_SDA;
            sda_s2_q <= sda_s1_q;
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    // The filtered level only follows the pin once three consecutive samples agree.
    logic scl_h1_q, scl_h2_q, scl_hold_q, sda_h1_q, sda_h2_q, sda_hold_q;

    assign scl_f = (scl_s2_q == scl_h1_q && scl_h1_q == scl_h2_q) ? scl_s2_q : scl_hold_q;
    assign sda_f = (sda_s2_q == sda_h1_q && sda_h1_q == sda_h2_q) ? sda_s2_q : sda_hold_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            scl_h1_q   <= 1'b1;
            scl_h2_q   <= 1'b1;
            scl_hold_q <= 1'b1;
            sda_h1_q   <= 1'b1;
            sda_h2_q   <= 1'b1;
            sda_hold_q <= 1'b1;
        end else begin
            scl_h1_q   <= scl_s2_q;
            scl_h2_q   <= scl_h1_q;
            scl_hold_q <= scl_f;
            sda_h1_q   <= sda_s2_q;
            sda_h2_q   <= sda_h1_q;
            sda_hold_q <= sda_f;
        end
    end
`else
    assign scl_f = scl_s2_q;
    assign sda_f = sda_s2_q;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            scl_dly_q <= 1'b1;
            sda_dly_q <= 1'b1;
        end else begin
            scl_dly_q <= scl_f;
            sda_dly_q <= sda_f;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_f & ~scl_dly_q;
    assign scl_fall  = ~scl_f & scl_dly_q;
    assign start_det = scl_f & scl_dly_q & sda_dly_q & ~sda_f;
    assign stop_det  = scl_f & scl_dly_q & ~sda_dly_q & sda_f;

    state_t               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [SIZE_DATA-1:0] shift_q, shift_d, tx_q, tx_d, rx_data_q, rx_data_d;
    logic [6:0]           own_q, own_d;
    logic                 rw_q, rw_d, mack_q, mack_d, oe_q, oe_d;
    logic                 rx_valid_q, rx_valid_d, tx_load_q, tx_load_d;
    logic                 start_q, start_d, stop_q, stop_d, busy_q, busy_d;
    logic [SIZE_DATA-1:0] byte_in, tx_next;

    always_comb begin
        byte_in    = {shift_q[SIZE_DATA-2:0], sda_f};
        tx_next    = i_tx_valid ? i_tx_data : {SIZE_DATA{1'b1}};
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        rx_data_d  = rx_data_q;
        own_d      = own_q;
        rw_d       = rw_q;
        mack_d     = mack_q;
        oe_d       = oe_q;
        rx_valid_d = 1'b0;
        tx_load_d  = 1'b0;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        busy_d     = busy_q & ~stop_q;
        if (start_det) begin
            start_d = 1'b1;
            busy_d  = 1'b1;
            state_d = ADDR;
            cnt_d   = 3'd0;
            oe_d    = 1'b0;
            mack_d  = 1'b0;
            own_d   = i_own_addr;
        end else if (stop_det) begin
            stop_d  = 1'b1;
            state_d = IDLE;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR, RX: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (state_q == RX) begin
                                rx_data_d  = byte_in;
                                rx_valid_d = 1'b1;
                                state_d    = RX_ACK;
                            end else if (byte_in[SIZE_DATA-1:1] == own_q && byte_in[SIZE_DATA-1:1] != 7'd0) begin
                                rw_d    = byte_in[0];
                                state_d = ADDR_ACK;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                // First SCL fall pulls SDA for the ACK, the next one ends it.
                ADDR_ACK, RX_ACK: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d  = 1'b0;
                            cnt_d = 3'd0;
                            if (state_q == RX_ACK || !rw_q) begin
                                state_d = RX;
                            end else begin
                                tx_d      = tx_next;
                                tx_load_d = i_tx_valid;
                                oe_d      = ~tx_next[SIZE_DATA-1];
                                state_d   = TX;
                            end
                        end
                    end
                end
                TX: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 3'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 3'd0) begin
                            oe_d    = 1'b0;
                            mack_d  = 1'b0;
                            state_d = TX_ACK;
                        end else begin
                            oe_d = ~tx_q[SIZE_DATA-2];
                            tx_d = {tx_q[SIZE_DATA-2:0], 1'b0};
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_f) state_d = IGNORE;
                        else       mack_d  = 1'b1;
                    end else if (scl_fall && mack_q) begin
                        tx_d      = tx_next;
                        tx_load_d = i_tx_valid;
                        oe_d      = ~tx_next[SIZE_DATA-1];
                        cnt_d     = 3'd0;
                        mack_d    = 1'b0;
                        state_d   = TX;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            mack_q     <= 1'b0;
            oe_q       <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_load_q  <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mack_q     <= mack_d;
            oe_q       <= oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_load_q  <= tx_load_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            busy_q     <= busy_d;
        end
        shift_q <= shift_d;
        tx_q    <= tx_d;
        own_q   <= own_d;
        rw_q    <= rw_d;
    end

    assign o_SDA_oe   = oe_q;
    assign o_rx_data  = rx_data_q;
    assign o_rx_valid = rx_valid_q;
    assign o_tx_load  = tx_load_q;
    assign o_start    = start_q;
    assign o_stop     = stop_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-level bus master with a transaction-level expectation model and a per-cycle monitor.
module tb_i2c_target;

    localparam int Q = 6;
`ifdef I2C_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst_n, m_scl, m_sda, sda_bus;
    logic [6:0] i_own_addr;
    logic [7:0] i_tx_data;
    logic       i_tx_valid;
    logic       o_SDA_oe, o_tx_load, o_rx_valid, o_start, o_stop, o_busy;
    logic [7:0] o_rx_data;

    always #5 i_clk = ~i_clk;
    assign sda_bus = m_sda & ~o_SDA_oe;

    i2c_target #(.SIZE_DATA(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_SCL(m_scl), .i_SDA(sda_bus),
        .o_SDA_oe(o_SDA_oe), .i_own_addr(i_own_addr), .i_tx_data(i_tx_data),
        .i_tx_valid(i_tx_valid), .o_tx_load(o_tx_load), .o_rx_data(o_rx_data),
        .o_rx_valid(o_rx_valid), .o_start(o_start), .o_stop(o_stop), .o_busy(o_busy)
    );

    int checks = 0, errors = 0;
    int n_start = 0, n_stop = 0, n_load = 0, n_rxv = 0;
    int cyc = 0, last_start_cyc = 0, t_sda = 0;
    logic [7:0] rxq[$];
    logic       exp_silent = 1'b0;
    logic [7:0] buf_d[4];
    logic       buf_v[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;

    // Pulse counting, received-byte scoreboard, and silence of non-addressed frames.
    always @(negedge i_clk) begin
        if (o_start) begin
            n_start++;
            last_start_cyc = cyc;
        end
        if (o_stop) n_stop++;
        if (o_tx_load) n_load++;
        if (o_rx_valid) begin
            n_rxv++;
            if (rxq.size() > 0) begin
                check("rx_data", o_rx_data, rxq.pop_front());
            end else begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected actual=%0h required=no_pulse", o_rx_data);
            end
        end
        if (exp_silent) check("silent_oe", o_SDA_oe, 0);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic clk_bit(input logic b, output logic s);
        m_sda = b;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        s = sda_bus;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic start_cond();
        m_sda = 1'b1;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        m_sda = 1'b0;
        t_sda = cyc;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic stop_cond();
        m_sda = 1'b0;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        m_sda = 1'b1;
        tick(Q);
    endtask

    task automatic send8(input logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    endtask

    // One complete frame; expectations derive from address match, direction and the byte tables.
    task automatic do_frame(input logic [7:0] addr, input int n, output int acks, output logic [7:0] last_rd);
        logic s, match;
        logic [7:0] rd, exp_b;
        logic [6:0] own;
        int st0, sp0, ld0, rv0, exp_ld, exp_rv;
        own = i_own_addr;
        match = (addr[7:1] == own) && (own != 7'd0);
        st0 = n_start; sp0 = n_stop; ld0 = n_load; rv0 = n_rxv;
        exp_ld = 0; exp_rv = 0; acks = 0; last_rd = 8'h00; rd = 8'h00;
        exp_silent = !match;
        if (addr[0]) begin
            i_tx_data  = buf_d[0];
            i_tx_valid = buf_v[0];
        end
        start_cond();
        i_own_addr = own ^ 7'h15;
        check("start_latency", last_start_cyc - t_sda, LAT);
        send8(addr);
        clk_bit(1'b1, s);
        check("addr_ack", s, !match);
        if (!s) acks++;
        check("busy_mid", o_busy, 1);
        for (int k = 0; k < n; k++) begin
            if (!addr[0]) begin
                if (match) begin
                    rxq.push_back(buf_d[k]);
                    exp_rv++;
                end
                send8(buf_d[k]);
                clk_bit(1'b1, s);
                check("data_ack", s, !match);
                if (!s) acks++;
            end else begin
                exp_b = (match && buf_v[k]) ? buf_d[k] : 8'hFF;
                if (match && buf_v[k]) exp_ld++;
                for (int i = 0; i < 8; i++) begin
                    clk_bit(1'b1, s);
                    rd = {rd[6:0], s};
                end
                check("read_byte", rd, exp_b);
                last_rd = rd;
                if (k + 1 < n) begin
                    i_tx_data  = buf_d[k+1];
                    i_tx_valid = buf_v[k+1];
                end
                clk_bit(k == n - 1, s);
                if (k == n - 1) check("oe_after_nack", o_SDA_oe, 0);
            end
        end
        stop_cond();
        tick(8);
        check("start_cnt", n_start - st0, 1);
        check("stop_cnt", n_stop - sp0, 1);
        check("tx_load_cnt", n_load - ld0, exp_ld);
        check("rx_valid_cnt", n_rxv - rv0, exp_rv);
        check("rx_queue_left", rxq.size(), 0);
        check("busy_end", o_busy, 0);
        exp_silent = 1'b0;
        i_own_addr = own;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks, st0, sp0, rv0;
        logic [7:0] rd, b;
        logic [6:0] own, a;
        logic s;
        i_rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
        i_own_addr = 7'h50; i_tx_data = 8'h00; i_tx_valid = 1'b0;
        tick(4);
        check("rst_oe", o_SDA_oe, 0);
        check("rst_rx_data", o_rx_data, 0);
        check("rst_rx_valid", o_rx_valid, 0);
        check("rst_tx_load", o_tx_load, 0);
        check("rst_start", o_start, 0);
        check("rst_stop", o_stop, 0);
        check("rst_busy", o_busy, 0);
        i_rst_n = 1'b1;
        tick(10);
        check("idle_no_start", n_start, 0);

        // Write 0xA0 then 0x3C.
        buf_d[0] = 8'h3C; buf_v[0] = 1'b1;
        do_frame(8'hA0, 1, acks, rd);
        check("wr_acks", acks, 2);
        check("wr_rx_data", o_rx_data, 8'h3C);

        // Read 0xA1 returning 0x96, master NACK.
        buf_d[0] = 8'h96; buf_v[0] = 1'b1;
        do_frame(8'hA1, 1, acks, rd);
        check("rd_bits", rd, 8'h96);
        check("rd_acks", acks, 1);

        // Foreign address 0xB0.
        buf_d[0] = 8'h55;
        do_frame(8'hB0, 1, acks, rd);
        check("foreign_acks", acks, 0);

        // Repeated START after 4 data bits.
        st0 = n_start; rv0 = n_rxv;
        start_cond();
        send8(8'hA0);
        clk_bit(1'b1, s);
        check("rs_addr_ack", s, 0);
        b = 8'($urandom);
        for (int i = 7; i >= 4; i--) clk_bit(b[i], s);
        start_cond();
        check("rs_start_cnt", n_start - st0, 2);
        send8(8'hA0);
        clk_bit(1'b1, s);
        check("rs_readdr_ack", s, 0);
        b = 8'($urandom);
        rxq.push_back(b);
        send8(b);
        clk_bit(1'b1, s);
        check("rs_data_ack", s, 0);
        stop_cond();
        tick(8);
        check("rs_rx_cnt", n_rxv - rv0, 1);

        // Reset pulse during the data ACK low phase.
        st0 = n_start; sp0 = n_stop; rv0 = n_rxv;
        start_cond();
        send8(8'hA0);
        clk_bit(1'b1, s);
        check("rst_addr_ack", s, 0);
        rxq.push_back(8'h5A);
        send8(8'h5A);
        m_sda = 1'b1;
        tick(Q);
        check("ack_before_rst", o_SDA_oe, 1);
        i_rst_n = 1'b0;
        tick(1);
        i_rst_n = 1'b1;
        check("oe_after_rst", o_SDA_oe, 0);
        m_scl = 1'b1;
        tick(2 * Q);
        m_scl = 1'b0;
        tick(Q);
        send8(8'h77);
        clk_bit(1'b1, s);
        check("post_rst_no_ack", s, 1);
        stop_cond();
        tick(8);
        check("rst_rx_cnt", n_rxv - rv0, 1);
        check("rst_start_cnt", n_start - st0, 1);
        check("rst_stop_cnt", n_stop - sp0, 1);
        buf_d[0] = 8'hC3; buf_v[0] = 1'b1;
        do_frame(8'hA0, 1, acks, rd);

        // Two-cycle SDA glitch while SCL is high.
        st0 = n_start; sp0 = n_stop;
        m_sda = 1'b0;
        tick(2);
        m_sda = 1'b1;
        tick(12);
`ifdef I2C_GLITCH_FILTER_EN
        check("glitch_start", n_start - st0, 0);
        check("glitch_stop", n_stop - sp0, 0);
`else
        check("glitch_start", n_start - st0, 1);
        check("glitch_stop", n_stop - sp0, 1);
`endif
        tick(4);

        for (int t = 0; t < 16; t++) begin
            own = 7'($urandom_range(1, 127));
            i_own_addr = own;
            for (int k = 0; k < 4; k++) begin
                buf_d[k] = 8'($urandom);
                buf_v[k] = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 2) != 0) begin
                a = own;
            end else begin
                a = 7'($urandom_range(0, 127));
                if (a == own) a = own ^ 7'h01;
            end
            do_frame({a, 1'($urandom_range(0, 1))}, int'($urandom_range(1, 3)), acks, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter SIZE_DATA, default 8, giving the data byte width; only 8 is supported.
REQ-002 SHALL have port i_clk, input, 1, the system clock; all logic is synchronous to its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, the reset: one clock, synchronous, active-low.
REQ-004 SHALL have port i_SCL, input, 1, the raw bus clock pin level, asynchronous to i_clk.
REQ-005 SHALL have port i_SDA, input, 1, the raw bus data pin level, asynchronous to i_clk.
REQ-006 SHALL have port o_SDA_oe, output, 1, where 1 means pull SDA low and 0 means release SDA.
REQ-007 SHALL have port i_own_addr, input, 7, the target address, sampled at START.
REQ-008 SHALL have port i_tx_data, input, SIZE_DATA, the next byte to return on a read.
REQ-009 SHALL have port i_tx_valid, input, 1, meaning i_tx_data holds a valid byte.
REQ-010 SHALL have port o_tx_load, output, 1, a 1-cycle pulse marking the cycle i_tx_data is latched.
REQ-011 SHALL have port o_rx_data, input-free output, SIZE_DATA, the last received write byte, held until the next byte.
REQ-012 SHALL have port o_rx_valid, output, 1, a 1-cycle pulse when o_rx_data updates.
REQ-013 SHALL have port o_start, output, 1, a 1-cycle pulse per START or repeated START.
REQ-014 SHALL have port o_stop, output, 1, a 1-cycle pulse per STOP.
REQ-015 SHALL have port o_busy, output, 1, high from a START up to and including the STOP cycle.

Function
REQ-016 SHALL pass i_SCL and i_SDA through 2-flop synchronizers (reset value 1), then through 1-cycle-delayed copies used for edge detection.
REQ-017 SHALL detect START as a synchronized SDA fall while synchronized SCL is high, and STOP as an SDA rise while SCL is high.
REQ-018 SHALL detect edges 3 i_clk cycles after a pin change when the filter is compiled out.
REQ-019 SHALL use FSM states IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK and IGNORE.
REQ-020 SHALL, on START from any state, pulse o_start, enter ADDR, clear the bit counter and release o_SDA_oe in that same cycle.
REQ-021 SHALL, on STOP from any state, pulse o_stop, enter IDLE and release o_SDA_oe.
REQ-022 SHALL shift SDA MSB-first on each SCL rise; a 3-bit counter with wrap 7->0 marks byte completion.
REQ-023 SHALL, in ADDR, compare the 8th bit received against {i_own_addr, R/W}.
REQ-024 SHALL, on an address match, enter ADDR_ACK; on a mismatch (including 0x00), enter IGNORE and never drive SDA.
REQ-025 SHALL assert o_SDA_oe from the SCL fall following the 8th rise until the next SCL fall, both for an ACK in ADDR_ACK and RX_ACK and for a 0 data bit in TX.
REQ-026 SHALL, after ADDR_ACK with R/W=0, enter RX.
REQ-027 SHALL, on the 8th rise in RX, update o_rx_data, pulse o_rx_valid, enter RX_ACK and always ACK.
REQ-028 SHALL, after ADDR_ACK with R/W=1 or after a TX_ACK ACK, latch i_tx_data and pulse o_tx_load on the ACK-ending SCL fall, or load 0xFF if i_tx_valid=0 with no pulse.
REQ-029 SHALL, in TX, drive o_SDA_oe = ~bit on each SCL fall, MSB first, and release SDA on the SCL fall after the 8th bit.
REQ-030 SHALL, in TX_ACK, sample SDA on SCL rise: 0 (ACK) returns to TX; 1 (NACK) goes to IGNORE.
REQ-031 SHALL, in IGNORE, leave o_SDA_oe=0 until START or STOP.
REQ-032 SHALL give START/STOP precedence over an SCL edge detected in the same cycle.

Reset
REQ-033 SHALL, while i_rst_n=0 at a clock edge, set state=IDLE, o_SDA_oe=0, o_rx_data=0, all pulses=0, o_busy=0 and synchronizers=1.
REQ-034 SHALL, on reset mid-transfer, release SDA on the next clock and wait for a fresh START, ignoring the remaining transfer.

Configuration
REQ-035 SHALL, when I2C_GLITCH_FILTER_EN is defined, change the filtered SCL/SDA only after 3 consecutive equal synchronized samples, adding 2 cycles of detect latency and rejecting pulses of 2 i_clk cycles or less.
REQ-036 SHALL, when I2C_GLITCH_FILTER_EN is undefined, build no filter, with latency per REQ-018.

Verification
REQ-037 SHALL test: i_own_addr=0x50, write 0xA0, 0x3C, STOP -> address ACK, o_rx_data=0x3C with 1 o_rx_valid pulse, 2 ACKs, o_stop pulse.
REQ-038 SHALL test: read 0xA1 with i_tx_data=0x96, i_tx_valid=1, master NACK -> SDA bits 1,0,0,1,0,1,1,0, o_tx_load once, IGNORE state, SDA released.
REQ-039 SHALL test: address 0xB0 against own 0x50 -> o_SDA_oe stays 0 for the whole frame, no rx/tx pulses.
REQ-040 SHALL test: repeated START after 4 data bits -> o_start pulse, counter cleared, next byte decoded as an address.
REQ-041 SHALL test: i_rst_n=0 for 1 cycle during the ACK low phase -> o_SDA_oe=0 next cycle, no o_rx_valid until a new START.
REQ-042 SHALL test, with I2C_GLITCH_FILTER_EN defined: a 2-cycle SDA low glitch while SCL is high -> no o_start.
